// File: rtl/single_port_ram_sync_if.sv
// Bus bundle for single_port_ram_sync: shared address, write data/enable and registered read data.
// With SPRAM_PARITY_EN defined the bundle also carries parity_inj and perr.
interface single_port_ram_sync_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] q;
`ifdef SPRAM_PARITY_EN
  logic                  parity_inj;
  logic                  perr;

  modport master (output data, output addr, output we, output parity_inj,
                  input q, input perr);
  modport slave  (input data, input addr, input we, input parity_inj,
                  output q, output perr);
`else
  modport master (output data, output addr, output we, input q);
  modport slave  (input data, input addr, input we, output q);
`endif
endinterface

// File: rtl/single_port_ram_sync.sv
// Synchronous single-port write-first RAM with a registered read port.
// Optional per-word even parity with error injection when SPRAM_PARITY_EN is defined.
module single_port_ram_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  single_port_ram_sync_if.slave bus
);

`ifdef SPRAM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

  // Zero-initialised so unwritten words never read back as X.
  logic [WORD_W-1:0]     mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] q_q = '0;
  logic [DATA_WIDTH-1:0] q_d;

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] wr_word;
  logic              mem_we;

  assign in_range = ({1'b0, bus.addr} < DEPTH_L);
  assign idx      = bus.addr[IDX_W-1:0];
  assign rd_word  = mem[idx];
  assign mem_we   = !rst && bus.we && in_range;

`ifdef SPRAM_PARITY_EN
  logic perr_q = 1'b0;
  logic perr_d;

  // Stored parity bit makes the word's total XOR even; parity_inj flips it.
  assign wr_word = {(^bus.data) ^ bus.parity_inj, bus.data};

  always_comb begin
    perr_d = 1'b0;
    if (!bus.we && in_range) begin
      perr_d = rd_word[DATA_WIDTH] ^ (^rd_word[DATA_WIDTH-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.perr = perr_q;
`else
  assign wr_word = bus.data;
`endif

  // Write-first: a write also forwards its data to q; out-of-range reads return 0.
  always_comb begin
    q_d = '0;
    if (bus.we) begin
      q_d = bus.data;
    end else if (in_range) begin
      q_d = rd_word[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wr_word;
    end
  end

  assign bus.q = q_q;

endmodule

// File: tb/tb_single_port_ram_sync.sv
// Scoreboard testbench for single_port_ram_sync: expected q values are queued per
// operation and popped one cycle later when the registered output is valid.
module tb_single_port_ram_sync;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] model [64];

  single_port_ram_sync_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  single_port_ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one operation away from the active edge, then wait until just after it.
  task automatic step(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    bus.we   = w;
    bus.addr = a;
    bus.data = d;
    @(posedge clk);
    #1;
    if (!r && w) model[a] = d;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      step(1'b1, 1'b0, 6'd0, 8'hFF);
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL reset_q[%0d] got=%h exp=%h", i, bus.q, e);
      end
    end
    exp_q.push_back(8'h00);
    step(1'b0, 1'b0, 6'd0, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (bus.q !== e) begin
      errors++;
      $display("FAIL reset_init_read got=%h exp=%h", bus.q, e);
    end
  endtask

  task automatic test_seq_write();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(i + 1));
      step(1'b0, 1'b1, 6'(i), 8'(i + 1));
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL seq_write@%0d got=%h exp=%h", i, bus.q, e);
      end
    end
  endtask

  task automatic test_readback();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(i + 1));
      step(1'b0, 1'b0, 6'(i), 8'hC3);
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL readback@%0d got=%h exp=%h", i, bus.q, e);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [5:0] a_tab [4] = '{6'd1, 6'd1, 6'd0, 6'd2};
    logic       w_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] e_tab [4] = '{8'h04, 8'h04, 8'h01, 8'h03};
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e_tab[i]);
      step(1'b0, w_tab[i], a_tab[i], w_tab[i] ? 8'h04 : 8'h99);
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL overwrite[%0d] got=%h exp=%h", i, bus.q, e);
      end
    end
  endtask

  // q must not follow input changes between edges.
  task automatic test_hold();
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = 6'd0;
    bus.data = 8'hEE;
    #1;
    checks++;
    if (bus.q !== 8'h03) begin
      errors++;
      $display("FAIL hold_between_edges got=%h exp=%h", bus.q, 8'h03);
    end
    bus.we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] a_tab [6] = '{6'd10, 6'd10, 6'd12, 6'd12, 6'd12, 6'd12};
    logic       w_tab [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] d_tab [6] = '{8'h5A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [7:0] e_tab [6] = '{8'h5A, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h33};
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(e_tab[i]);
      step(1'b0, w_tab[i], a_tab[i], d_tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, bus.q, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       r_tab [3] = '{1'b0, 1'b1, 1'b0};
    logic       w_tab [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d_tab [3] = '{8'hAA, 8'h55, 8'h00};
    logic [7:0] e_tab [3] = '{8'hAA, 8'h00, 8'hAA};
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e_tab[i]);
      step(r_tab[i], w_tab[i], 6'd5, d_tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%h exp=%h", i, bus.q, e);
      end
    end
  endtask

  task automatic test_random();
    logic       r, w;
    logic [5:0] a;
    logic [7:0] d, e;
    for (int i = 0; i < 80; i++) begin
      r = ($urandom_range(0, 15) == 0);
      w = $urandom_range(0, 1) == 1;
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom_range(0, 255));
      if (r)      exp_q.push_back(8'h00);
      else if (w) exp_q.push_back(d);
      else        exp_q.push_back(model[a]);
      step(r, w, a, d);
      e = exp_q.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL random[%0d] rst=%0b we=%0b addr=%0d got=%h exp=%h", i, r, w, a, bus.q, e);
      end
    end
    rst = 1'b0;
  endtask

`ifdef SPRAM_PARITY_EN
  task automatic test_parity();
    logic [5:0] a_tab [4] = '{6'd3, 6'd3, 6'd4, 6'd4};
    logic       w_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       i_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       p_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] e;
    logic       ep [$];
    logic       pe;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h0F);
      ep.push_back(p_tab[i]);
      bus.parity_inj = i_tab[i];
      step(1'b0, w_tab[i], a_tab[i], 8'h0F);
      bus.parity_inj = 1'b0;
      e  = exp_q.pop_front();
      pe = ep.pop_front();
      checks++;
      if (bus.q !== e) begin
        errors++;
        $display("FAIL parity_q[%0d] got=%h exp=%h", i, bus.q, e);
      end
      checks++;
      if (bus.perr !== pe) begin
        errors++;
        $display("FAIL parity_perr[%0d] got=%b exp=%b", i, bus.perr, pe);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
`ifdef SPRAM_PARITY_EN
    bus.parity_inj = 1'b0;
`endif
    test_reset();
    test_seq_write();
    test_readback();
    test_hold();
    test_overwrite();
    test_back_to_back();
    test_reset_mid();
`ifdef SPRAM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_port_ram_sync.md
Name: single_port_ram_sync

Overview:
- Synchronous single-port RAM: one shared address bus for reads and writes, one write-enable, one registered read-data output.
- Default geometry is 64 words x 8 bits.
- Used as a small on-chip scratch/data store. All activity occurs on the rising edge of the single clock.
- Write-first (write-through) port behaviour.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of data/q.
- ADDR_WIDTH, 6, address width.
- DEPTH, 2**ADDR_WIDTH (64), number of words; must not exceed 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_WIDTH  write data.
- addr  input  ADDR_WIDTH  word address, shared by read and write.
- we  input  1  write enable; 1 = write, 0 = read.
- q  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - q <= 0.
  - we is ignored in that cycle and no write occurs.
  - Memory contents are preserved across reset.
  - rst has priority over we.
- Power-up: memory array and q initialise to 0 in simulation (initial block). Synthesis may ignore this.
- Write (rst=0, we=1 at edge):
  - mem[addr] <= data.
  - q <= data in the same edge (write-first). Written value is visible on q one cycle after the write.
- Read (rst=0, we=0 at edge):
  - q <= mem[addr].
  - Latency is 1 clock from addr sampled to q valid.
- q holds its value between edges and changes only on a rising edge.
- Address out of range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_WIDTH):
  - Write is dropped.
  - Read returns 0.
- Back-to-back operations:
  - Write to A followed by a read of A on the next edge returns the new data (no hazard).
  - Consecutive writes to the same address: the last one wins.
- No combinational path from any input to q.
- No X propagation from an unwritten location, because of the zero init.

Optional Feature:
- Macro: SPRAM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit, computed from data on write.
  - Extra output perr (1 bit, registered, reset 0) is driven on every read.
  - perr = 1 when the stored parity does not match the XOR of the stored data bits.
  - On write cycles perr <= 0.
  - Input port parity_inj (1 bit) inverts the stored parity bit on a write, for error-injection testing.
- When not defined:
  - No parity storage.
  - Ports perr and parity_inj do not exist.

Test Plan:
- Reset: rst=1 for 2 edges, then release -> q=0x00; a read of addr 0 returns 0x00 (init value).
- Sequential writes: we=1, write 0x01@0, 0x02@1, 0x03@2 on successive edges -> q shows 0x01, 0x02, 0x03 one cycle after each write (write-first).
- Readback: we=0, addr=0,1,2 on successive edges -> q = 0x01, 0x02, 0x03, each one cycle after its address is applied.
- Overwrite: we=1, data=0x04, addr=1; then we=0, addr=1 -> q=0x04 after both edges; addr=0 and addr=2 still read 0x01 and 0x03.
- Reset mid-operation: write 0xAA@5, assert rst during a cycle with we=1, data=0x55, addr=5 -> q=0x00, no write occurs; after release, reading addr 5 returns 0xAA.
- Parity (SPRAM_PARITY_EN): write 0x0F@3 with parity_inj=1, then read addr 3 -> q=0x0F, perr=1; write 0x0F@4 with parity_inj=0, then read addr 4 -> perr=0.
